mc_control_fsm: RTL

- Multicycle control sequencer for the 32-bit RISC datapath.
- Decodes opcode/func from IR and drives every datapath load/read/write/mux/ALU-function control, one microstep per clock.
- Variable CPI: 3–6 cycles per instruction.
- Adds run/halt gating, an illegal-opcode flag and an instruction-retired pulse for the top-level and testbench.

---
 rtl/mc_isa_pkg.sv | 46 ++++
 rtl/mc_control_fsm_if.sv | 33 +++
 rtl/mc_decode.sv | 27 ++
 rtl/mc_control_fsm.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mc_isa_pkg.sv
// Shared ISA constants, FSM state encoding and the control-word layout for the
// multicycle RISC control sequencer.
package mc_isa_pkg;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;

    localparam logic [5:0] OP_RALU  = 6'b000000;
    localparam logic [5:0] OP_STORE = 6'b000010;
    localparam logic [5:0] OP_LOAD  = 6'b000011;
    localparam logic [5:0] OP_BR    = 6'b000100;
    localparam logic [5:0] OP_BMI   = 6'b000101;
    localparam logic [5:0] OP_BPL   = 6'b000110;
    localparam logic [5:0] OP_BZ    = 6'b000111;
    localparam logic [5:0] OP_MOV   = 6'b001000;
    localparam logic [5:0] OP_CMOV  = 6'b001001;
    localparam logic [5:0] OP_LDI   = 6'b001010;
    localparam logic [5:0] OP_NOP   = 6'b001011;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [1:0] MV_WB   = 2'd0;
    localparam logic [1:0] MV_SIGN = 2'd1;
    localparam logic [1:0] MV_A    = 2'd2;
    localparam logic [1:0] MV_IMM  = 2'd3;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_LMD, S_WBALU,
        S_WBLOAD, S_WBMOVE, S_BRANCH, S_DONE, S_HALT
    } state_e;

    typedef enum logic [3:0] {
        C_RALU, C_IALU, C_STORE, C_LOAD, C_BR, C_BMI, C_BPL, C_BZ,
        C_MOV, C_CMOV, C_LDI, C_NOP, C_HALT, C_ILL
    } iclass_e;

    typedef struct packed {
        logic       LoadPC, PCSel, ReadIM, LoadNPC, LoadIR;
        logic       ReadRP1, ReadRP2, WriteRP, LoadA, LoadB, IMMsel, LoadIMM;
        logic       MUXALU1, MUXALU2, LoadALUOut;
        logic [3:0] ALUFunc;
        logic       ReadDM, WriteDM, LoadLMD, MUXWB;
        logic [1:0] MUXMOVE;
        logic       halted, illegal, instr_done;
    } ctl_t;

endpackage

// File: rtl/mc_control_fsm_if.sv
// Datapath <-> control sequencer bundle: IR fields and run in, control word out.
interface mc_control_fsm_if;
    logic        run;
    logic [5:0]  opcode;
    logic [3:0]  func;
    logic [31:0] a_val;
    logic        LoadPC, PCSel, ReadIM, LoadNPC, LoadIR;
    logic        ReadRP1, ReadRP2, WriteRP, LoadA, LoadB, IMMsel, LoadIMM;
    logic        MUXALU1, MUXALU2, LoadALUOut;
    logic [3:0]  ALUFunc;
    logic        ReadDM, WriteDM, LoadLMD, MUXWB;
    logic [1:0]  MUXMOVE;
    logic        halted, illegal, instr_done;
    logic [3:0]  state_dbg;

    modport master (
        input  run, opcode, func, a_val,
        output LoadPC, PCSel, ReadIM, LoadNPC, LoadIR,
               ReadRP1, ReadRP2, WriteRP, LoadA, LoadB, IMMsel, LoadIMM,
               MUXALU1, MUXALU2, LoadALUOut, ALUFunc,
               ReadDM, WriteDM, LoadLMD, MUXWB, MUXMOVE,
               halted, illegal, instr_done, state_dbg
    );

    modport slave (
        output run, opcode, func, a_val,
        input  LoadPC, PCSel, ReadIM, LoadNPC, LoadIR,
               ReadRP1, ReadRP2, WriteRP, LoadA, LoadB, IMMsel, LoadIMM,
               MUXALU1, MUXALU2, LoadALUOut, ALUFunc,
               ReadDM, WriteDM, LoadLMD, MUXWB, MUXMOVE,
               halted, illegal, instr_done, state_dbg
    );
endinterface

// File: rtl/mc_decode.sv
// Combinational opcode -> instruction class decoder; C_ILL marks undefined opcodes.
module mc_decode
    import mc_isa_pkg::*;
(
    input  logic [5:0] i_opcode,
    output iclass_e    o_class
);
    always_comb begin
        o_class = C_ILL;
        casez (i_opcode)
            OP_RALU:   o_class = C_RALU;
            6'b01????: o_class = C_IALU;
            OP_STORE:  o_class = C_STORE;
            OP_LOAD:   o_class = C_LOAD;
            OP_BR:     o_class = C_BR;
            OP_BMI:    o_class = C_BMI;
            OP_BPL:    o_class = C_BPL;
            OP_BZ:     o_class = C_BZ;
            OP_MOV:    o_class = C_MOV;
            OP_CMOV:   o_class = C_CMOV;
            OP_LDI:    o_class = C_LDI;
            OP_NOP:    o_class = C_NOP;
            OP_HALT:   o_class = C_HALT;
            default:   o_class = C_ILL;
        endcase
    end
endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control sequencer: one microstep per clock, Moore control word
// decoded from the current state and the opcode latched at DECODE.
module mc_control_fsm
    import mc_isa_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    mc_control_fsm_if.master  bus
);
    state_e     r_state, w_next;
    logic [5:0] r_op;
    logic [3:0] r_func;
    logic [5:0] w_op;
    logic [3:0] w_func;
    iclass_e    w_class;
    logic       w_taken;
    ctl_t       w_ctl, w_out;

    // IR is already valid in DECODE, so that state decodes it live; later states use the latched copy.
    assign w_op   = (r_state == S_DECODE) ? bus.opcode : r_op;
    assign w_func = (r_state == S_DECODE) ? bus.func   : r_func;

    mc_decode u_decode (.i_opcode(w_op), .o_class(w_class));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_op    <= '0;
            r_func  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_op   <= bus.opcode;
                r_func <= bus.func;
            end
        end
    end

    always_comb begin
        w_taken = 1'b0;
        case (w_class)
            C_BR:    w_taken = 1'b1;
            C_BMI:   w_taken = bus.a_val[31];
            C_BPL:   w_taken = !bus.a_val[31];
            C_BZ:    w_taken = (bus.a_val == 32'd0);
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_ctl         = '0;
        w_ctl.ALUFunc = ALU_ADD;
        w_next        = r_state;
        case (r_state)
            S_FETCH: begin
                w_ctl.ReadIM  = bus.run;
                w_ctl.LoadIR  = bus.run;
                w_ctl.LoadNPC = bus.run;
                if (bus.run) w_next = S_DECODE;
            end
            S_DECODE: begin
                w_ctl.ReadRP1 = 1'b1;
                w_ctl.ReadRP2 = 1'b1;
                w_ctl.LoadA   = 1'b1;
                w_ctl.LoadB   = 1'b1;
                w_ctl.LoadIMM = 1'b1;
                w_ctl.IMMsel  = (w_class == C_BR);
                case (w_class)
                    C_MOV, C_CMOV, C_LDI: w_next = S_WBMOVE;
                    C_NOP:                w_next = S_DONE;
                    C_HALT:               w_next = S_HALT;
                    C_ILL: begin
                        w_ctl.illegal = 1'b1;
                        w_next        = S_DONE;
                    end
                    default:              w_next = S_EXEC;
                endcase
            end
            S_EXEC: begin
                w_ctl.LoadALUOut = 1'b1;
                w_next           = S_WBALU;
                case (w_class)
                    C_RALU: w_ctl.ALUFunc = w_func;
                    C_IALU: begin
                        w_ctl.ALUFunc = w_op[3:0];
                        w_ctl.MUXALU2 = 1'b1;
                    end
                    C_LOAD, C_STORE: begin
                        w_ctl.MUXALU2 = 1'b1;
                        w_next        = S_MEM;
                    end
                    C_BR, C_BMI, C_BPL, C_BZ: begin
                        w_ctl.MUXALU1 = 1'b1;
                        w_ctl.MUXALU2 = 1'b1;
                        w_next        = S_BRANCH;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                if (w_class == C_LOAD) begin
                    w_ctl.ReadDM = 1'b1;
                    w_next       = S_LMD;
                end else begin
                    w_ctl.WriteDM    = 1'b1;
                    w_ctl.LoadPC     = 1'b1;
                    w_ctl.instr_done = 1'b1;
                    w_next           = S_FETCH;
                end
            end
            S_LMD: begin
                w_ctl.LoadLMD = 1'b1;
                w_next        = S_WBLOAD;
            end
            S_WBALU, S_WBLOAD: begin
                w_ctl.WriteRP    = 1'b1;
                w_ctl.MUXWB      = (r_state == S_WBALU);
                w_ctl.MUXMOVE    = MV_WB;
                w_ctl.LoadPC     = 1'b1;
                w_ctl.instr_done = 1'b1;
                w_next           = S_FETCH;
            end
            S_WBMOVE: begin
                w_ctl.WriteRP    = 1'b1;
                w_ctl.LoadPC     = 1'b1;
                w_ctl.instr_done = 1'b1;
                w_next           = S_FETCH;
                case (w_class)
                    C_MOV:   w_ctl.MUXMOVE = MV_A;
                    C_CMOV: begin
                        // A-B through the ALU so the datapath sign flag selects the source.
                        w_ctl.MUXMOVE = MV_SIGN;
                        w_ctl.ALUFunc = ALU_SUB;
                    end
                    default: w_ctl.MUXMOVE = MV_IMM;
                endcase
            end
            S_BRANCH: begin
                w_ctl.LoadPC     = 1'b1;
                w_ctl.PCSel      = w_taken;
                w_ctl.instr_done = 1'b1;
                w_next           = S_FETCH;
            end
            S_DONE: begin
                w_ctl.LoadPC     = 1'b1;
                w_ctl.instr_done = 1'b1;
                w_next           = S_FETCH;
            end
            S_HALT:  w_ctl.halted = 1'b1;
            default: w_next = S_FETCH;
        endcase
    end

    // Reset forces the whole control word low at once, even while run is high in FETCH.
    assign w_out = rst ? '0 : w_ctl;

    assign bus.LoadPC     = w_out.LoadPC;
    assign bus.PCSel      = w_out.PCSel;
    assign bus.ReadIM     = w_out.ReadIM;
    assign bus.LoadNPC    = w_out.LoadNPC;
    assign bus.LoadIR     = w_out.LoadIR;
    assign bus.ReadRP1    = w_out.ReadRP1;
    assign bus.ReadRP2    = w_out.ReadRP2;
    assign bus.WriteRP    = w_out.WriteRP;
    assign bus.LoadA      = w_out.LoadA;
    assign bus.LoadB      = w_out.LoadB;
    assign bus.IMMsel     = w_out.IMMsel;
    assign bus.LoadIMM    = w_out.LoadIMM;
    assign bus.MUXALU1    = w_out.MUXALU1;
    assign bus.MUXALU2    = w_out.MUXALU2;
    assign bus.LoadALUOut = w_out.LoadALUOut;
    assign bus.ALUFunc    = w_out.ALUFunc;
    assign bus.ReadDM     = w_out.ReadDM;
    assign bus.WriteDM    = w_out.WriteDM;
    assign bus.LoadLMD    = w_out.LoadLMD;
    assign bus.MUXWB      = w_out.MUXWB;
    assign bus.MUXMOVE    = w_out.MUXMOVE;
    assign bus.halted     = w_out.halted;
    assign bus.illegal    = w_out.illegal;
    assign bus.instr_done = w_out.instr_done;
    assign bus.state_dbg  = r_state;
endmodule
